// File: rtl/execute_hazard_ctrl_pkg.sv
// Shared constants for the execute-stage hazard controller: forward selects,
// multi-cycle FSM states and the occupancy counter width.
package execute_hazard_ctrl_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam int         CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } hz_state_e;
endpackage

// File: rtl/execute_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. master = pipeline side, slave = controller.
interface execute_hazard_ctrl_if;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       register_file_wr_en_E, sel_result_E;
  logic       register_file_wr_en_M, register_file_wr_en_W;
  logic       branch_taken_E, mc_op_E;
  logic [1:0] fwdA_E, fwdB_E;
  logic       stall_F, stall_D, stall_E, flush_D, flush_E, flush_M;
  logic       mc_busy, mc_done;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           register_file_wr_en_E, sel_result_E,
           register_file_wr_en_M, register_file_wr_en_W,
           branch_taken_E, mc_op_E,
    input  fwdA_E, fwdB_E, stall_F, stall_D, stall_E,
           flush_D, flush_E, flush_M, mc_busy, mc_done
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           register_file_wr_en_E, sel_result_E,
           register_file_wr_en_M, register_file_wr_en_W,
           branch_taken_E, mc_op_E,
    output fwdA_E, fwdB_E, stall_F, stall_D, stall_E,
           flush_D, flush_E, flush_M, mc_busy, mc_done
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-operand bypass select: the younger M-stage result wins over W; x0 never forwards.
module hazard_fwd_sel
  import execute_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic       we_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       we_w_i,
  output logic [1:0] fwd_o
);
  always_comb begin
    fwd_o = FWD_REG;
    if (we_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i))
      fwd_o = FWD_M;
    else if (we_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i))
      fwd_o = FWD_W;
  end
endmodule

// File: rtl/execute_hazard_ctrl.sv
// Execute-stage hazard control: operand forwarding, load-use stall, branch flush
// and multi-cycle op occupancy. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module execute_hazard_ctrl
  import execute_hazard_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic                clk,
  input  logic                clr_n,
  execute_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
`endif
);
  hz_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0][4:0]   rs_e;
  logic [1:0][1:0]   fwd;
  logic              load_use, occupied, free;

  assign rs_e = {hz.rs2_E, hz.rs1_E};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    hazard_fwd_sel u_fwd (
      .rs_i   (rs_e[g]),
      .rd_m_i (hz.rd_M),
      .we_m_i (hz.register_file_wr_en_M),
      .rd_w_i (hz.rd_W),
      .we_w_i (hz.register_file_wr_en_W),
      .fwd_o  (fwd[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_use = hz.sel_result_E && hz.register_file_wr_en_E && (hz.rd_E != 5'd0) &&
                    ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
  // The op's first occupancy cycle is the IDLE cycle in which it arrives.
  assign occupied = (state_q == ST_BUSY) || ((state_q == ST_IDLE) && hz.mc_op_E);
  assign free     = !occupied;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (hz.mc_op_E) begin
        cnt_d = CNT_W'(MC_LATENCY - 2);
        // A 2-cycle op is fully covered by the arrival cycle plus RELEASE.
        state_d = (MC_LATENCY == 2) ? ST_RELEASE : ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hz.fwdA_E  = FWD_REG;
    hz.fwdB_E  = FWD_REG;
    hz.stall_F = 1'b0;
    hz.stall_D = 1'b0;
    hz.stall_E = 1'b0;
    hz.flush_D = 1'b0;
    hz.flush_E = 1'b0;
    hz.flush_M = 1'b0;
    hz.mc_busy = 1'b0;
    hz.mc_done = 1'b0;
    if (clr_n) begin
      hz.fwdA_E  = fwd[0];
      hz.fwdB_E  = fwd[1];
      hz.mc_done = (state_q == ST_RELEASE);
      if (occupied) begin
        hz.stall_F = 1'b1;
        hz.stall_D = 1'b1;
        hz.stall_E = 1'b1;
        hz.flush_M = 1'b1;
        hz.mc_busy = 1'b1;
      end else if (free && hz.branch_taken_E) begin
        hz.flush_D = 1'b1;
        hz.flush_E = 1'b1;
      end else if (free && load_use) begin
        hz.stall_F = 1'b1;
        hz.stall_D = 1'b1;
        hz.flush_E = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, hz.stall_D};
      flush_cnt_q <= flush_cnt_q + {31'd0, hz.flush_E};
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_execute_hazard_ctrl.sv
// Directed + randomized bench for execute_hazard_ctrl against an occupancy-count model.
module tb_execute_hazard_ctrl;
  localparam int L = 4;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  execute_hazard_ctrl_if hz ();
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  execute_hazard_ctrl #(.MC_LATENCY(L)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: remaining BUSY cycles after the arrival cycle, plus a pending-done flag.
  int busy_left = 0;
  bit rel = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (hz.register_file_wr_en_M && hz.rd_M != 0 && hz.rd_M == rs) return 2'b10;
    if (hz.register_file_wr_en_W && hz.rd_W != 0 && hz.rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    hz.rs1_D = 0; hz.rs2_D = 0; hz.rs1_E = 0; hz.rs2_E = 0;
    hz.rd_E = 0; hz.rd_M = 0; hz.rd_W = 0;
    hz.register_file_wr_en_E = 0; hz.sel_result_E = 0;
    hz.register_file_wr_en_M = 0; hz.register_file_wr_en_W = 0;
    hz.branch_taken_E = 0; hz.mc_op_E = 0;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic cycle(input string tag);
    bit busy, act, lu, br;
    bit e_sd, e_fe;
    @(negedge clk);
    busy = clr_n && (busy_left > 0 || (!rel && hz.mc_op_E));
    act  = clr_n && !busy;
    br   = hz.branch_taken_E;
    lu   = hz.sel_result_E && hz.register_file_wr_en_E && hz.rd_E != 0 &&
           (hz.rd_E == hz.rs1_D || hz.rd_E == hz.rs2_D);
    e_sd = busy || (act && lu && !br);
    e_fe = act && (br || lu);
    chk({tag, ".fwdA"},    32'(hz.fwdA_E),  clr_n ? 32'(ref_fwd(hz.rs1_E)) : 32'd0);
    chk({tag, ".fwdB"},    32'(hz.fwdB_E),  clr_n ? 32'(ref_fwd(hz.rs2_E)) : 32'd0);
    chk({tag, ".stallF"},  32'(hz.stall_F), 32'(e_sd));
    chk({tag, ".stallD"},  32'(hz.stall_D), 32'(e_sd));
    chk({tag, ".stallE"},  32'(hz.stall_E), 32'(busy));
    chk({tag, ".flushD"},  32'(hz.flush_D), 32'(act && br));
    chk({tag, ".flushE"},  32'(hz.flush_E), 32'(e_fe));
    chk({tag, ".flushM"},  32'(hz.flush_M), 32'(busy));
    chk({tag, ".mcbusy"},  32'(hz.mc_busy), 32'(busy));
    chk({tag, ".mcdone"},  32'(hz.mc_done), 32'(clr_n && rel));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".stallcnt"}, stall_cnt, 32'(m_stall));
    chk({tag, ".flushcnt"}, flush_cnt, 32'(m_flush));
`endif
    @(posedge clk);
    if (!clr_n) begin
      busy_left = 0; rel = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_stall += int'(e_sd);
      m_flush += int'(e_fe);
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) rel = 1;
      end else if (rel) begin
        rel = 0;
      end else if (hz.mc_op_E) begin
        busy_left = L - 2;
        if (busy_left == 0) rel = 1;
      end
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    clr_n = 0;
    hz.rs1_E = 5; hz.rd_M = 5; hz.register_file_wr_en_M = 1;
    hz.mc_op_E = 1;
    cycle("rst0");
    cycle("rst1");

    clear_inputs();
    clr_n = 1;
    hz.rs1_E = 5; hz.rd_M = 5; hz.register_file_wr_en_M = 1;
    hz.rd_W = 5; hz.register_file_wr_en_W = 1;
    cycle("fwd_m");
    hz.rd_M = 0;
    cycle("fwd_w");
    hz.rs2_E = 5; hz.rs1_E = 3;
    cycle("fwd_b");

    clear_inputs();
    hz.sel_result_E = 1; hz.register_file_wr_en_E = 1; hz.rd_E = 7; hz.rs2_D = 7;
    cycle("lu");
    clear_inputs();
    cycle("lu_after");

    hz.sel_result_E = 1; hz.register_file_wr_en_E = 1; hz.rd_E = 7; hz.rs1_D = 7;
    hz.branch_taken_E = 1;
    cycle("lu_br");
    clear_inputs();
    hz.sel_result_E = 1; hz.register_file_wr_en_E = 1; hz.rs1_D = 0;
    cycle("lu_x0");

    clear_inputs();
    hz.mc_op_E = 1;
    for (int i = 0; i < 6; i++) cycle($sformatf("mc%0d", i));
    hz.mc_op_E = 0;
    cycle("mc_idle");

    hz.mc_op_E = 1;
    cycle("abort_arr");
    cycle("abort_b1");
    clr_n = 0;
    cycle("abort_rst");
    clr_n = 1; hz.mc_op_E = 0;
    cycle("abort_idle");
    cycle("abort_idle2");

    for (int i = 0; i < 500; i++) begin
      clr_n = ($urandom_range(0, 39) != 0);
      hz.rs1_D = 5'($urandom_range(0, 3)); hz.rs2_D = 5'($urandom_range(0, 3));
      hz.rs1_E = 5'($urandom_range(0, 3)); hz.rs2_E = 5'($urandom_range(0, 3));
      hz.rd_E  = 5'($urandom_range(0, 3)); hz.rd_M  = 5'($urandom_range(0, 3));
      hz.rd_W  = 5'($urandom_range(0, 3));
      hz.register_file_wr_en_E = 1'($urandom);
      hz.sel_result_E          = 1'($urandom);
      hz.register_file_wr_en_M = 1'($urandom);
      hz.register_file_wr_en_W = 1'($urandom);
      hz.branch_taken_E = ($urandom_range(0, 5) == 0);
      hz.mc_op_E        = ($urandom_range(0, 7) == 0);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_hazard_ctrl.md
EXECUTE_HAZARD_CTRL -- requirements
Module: execute_hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_LATENCY, default 4, giving execute-stage occupancy in cycles of a multi-cycle op (legal 2..16).
REQ-002 SHALL have ports clk  in  1  pipeline clock; clr_n  in  1  synchronous active-low reset.
REQ-003 SHALL have ports rs1_D, rs2_D  in  5 each  decode source regs; rs1_E, rs2_E  in  5 each  execute source regs.
REQ-004 SHALL have ports rd_E  in  5  execute wr addr; register_file_wr_en_E  in  1; sel_result_E  in  1  execute op is a load.
REQ-005 SHALL have ports rd_M  in  5; register_file_wr_en_M  in  1; rd_W  in  5; register_file_wr_en_W  in  1.
REQ-006 SHALL have ports branch_taken_E  in  1  redirect; mc_op_E  in  1  execute op is multi-cycle.
REQ-007 SHALL have ports fwdA_E, fwdB_E  out  2 each  forward selects (00 register, 01 result_W, 10 ALU_output_M).
REQ-008 SHALL have ports stall_F, stall_D, stall_E, flush_D, flush_E, flush_M  out  1 each; mc_busy  out  1; mc_done  out  1.

Function
REQ-009 fwdA_E SHALL be 10 when register_file_wr_en_M and rd_M!=0 and rd_M==rs1_E; else 01 when the same holds for W; else 00 (M beats W); fwdB_E identical on rs2_E.
REQ-010 Load-use hazard SHALL be sel_result_E & register_file_wr_en_E & rd_E!=0 & (rd_E==rs1_D | rd_E==rs2_D).
REQ-011 On load-use hazard with FSM not BUSY: stall_F=stall_D=flush_E=1 for exactly that cycle.
REQ-012 branch_taken_E with FSM not BUSY SHALL assert flush_D=flush_E=1 and SHALL suppress load-use stall_F/stall_D that cycle.
REQ-013 FSM states IDLE, BUSY, RELEASE; IDLE->BUSY when mc_op_E=1, loading counter with MC_LATENCY-2.
REQ-014 In BUSY: stall_F=stall_D=stall_E=flush_M=1, mc_busy=1; flush_D/flush_E forced 0; counter decrements each cycle.
REQ-015 BUSY->RELEASE when counter==0; RELEASE asserts mc_done=1 for one cycle, no stalls, mc_op_E ignored, branch/load-use handled per REQ-011/012.
REQ-016 RELEASE->IDLE unconditionally; total execute occupancy SHALL equal MC_LATENCY cycles.
REQ-017 In IDLE the cycle mc_op_E rises, stalls from REQ-014 SHALL already apply combinationally (first occupancy cycle).
REQ-018 Counter width SHALL be 4 bits; no wrap: decrement disabled at 0.

Reset
REQ-019 clr_n=0 at a clk edge SHALL force state IDLE, counter 0, mc_done 0; mid-BUSY reset aborts op with no mc_done.
REQ-020 While clr_n=0 all stall/flush/mc_busy outputs SHALL be 0 and fwd selects 00.

Configuration
REQ-021 Macro HAZARD_PERF_CNT_EN: when defined, adds out ports stall_cnt, flush_cnt (32 bits each), counting cycles with stall_D=1 and with flush_E=1, wrapping at 2^32, zeroed by reset.
REQ-022 Without HAZARD_PERF_CNT_EN the ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-023 Shared package SHALL hold the forward-select constants (FWD_REG, FWD_W, FWD_M) and the FSM state enum.
REQ-024 One sub-module hazard_fwd_sel (combinational per-operand forward select, instantiated twice) SHALL be used.

Verification
REQ-025 rs1_E=5, rd_M=5 wr_en_M=1, rd_W=5 wr_en_W=1 -> fwdA_E=10; rd_M=0 instead -> fwdA_E=01.
REQ-026 load rd_E=7, rs2_D=7 -> one cycle stall_F=stall_D=flush_E=1, then 0.
REQ-027 load hazard plus branch_taken_E same cycle -> flush_D=flush_E=1, stall_F=stall_D=0.
REQ-028 mc_op_E=1 held, MC_LATENCY=4 -> stall_E high 3 cycles, mc_done high on 4th, next cycle IDLE.
REQ-029 clr_n=0 on 2nd BUSY cycle -> next cycle IDLE, all outputs 0, no mc_done.
REQ-030 HAZARD_PERF_CNT_EN defined, 3 load-use stalls -> stall_cnt=3, flush_cnt=3.
